// File: rtl/mul_fp16_driver_if.sv
// Handshake bundle between the FP16 multiply driver, its caller, the multiplier and the consumer.
// The slave modport is the driver; the master modport is the environment around it.
interface mul_fp16_driver_if #(
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             mul_start;
  logic [15:0]      mul_a;
  logic [15:0]      mul_b;
  logic [15:0]      mul_result;
  logic             mul_done;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             err;

  modport slave (
    input  in_valid, in_a, in_b, in_tag, mul_result, mul_done, out_ready,
    output in_ready, mul_start, mul_a, mul_b, out_valid, out_result, out_tag, err
  );

  modport master (
    output in_valid, in_a, in_b, in_tag, mul_result, mul_done, out_ready,
    input  in_ready, mul_start, mul_a, mul_b, out_valid, out_result, out_tag, err
  );
endinterface

// File: rtl/mul_fp16_driver.sv
// Credit-based driver for mul_fp16: in-order tag FIFO plus result buffer with guaranteed slots.
// Optional MUL_DRV_TIMEOUT_EN builds a stall timeout and stray-done detector driving err.
module mul_fp16_driver #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input logic              clk,
  input logic              nRST,
  mul_fp16_driver_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 16 + TAG_W;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [EW-1:0]    res_mem [DEPTH];

  logic [AW-1:0] tag_wr_q, tag_rd_q, res_wr_q, res_rd_q;
  logic [CW-1:0] occ_q, occ_d, infl_q, infl_d;
  logic [CW:0]   used;
  logic          accept, done_ok, pop;

  // Buffered plus in-flight never exceeds DEPTH, so every issued multiply owns a slot.
  assign used          = {1'b0, occ_q} + {1'b0, infl_q};
  assign bus.in_ready  = used < DEPTH_C;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.mul_start = accept;
  assign bus.mul_a     = bus.in_a;
  assign bus.mul_b     = bus.in_b;

  assign done_ok       = bus.mul_done & (infl_q != '0);
  assign bus.out_valid = occ_q != '0;
  assign pop           = bus.out_valid & bus.out_ready;
  assign {bus.out_result, bus.out_tag} = res_mem[res_rd_q];

  always_comb begin
    occ_d  = occ_q;
    infl_d = infl_q;
    if (done_ok) occ_d = occ_d + CW'(1);
    if (pop)     occ_d = occ_d - CW'(1);
    if (accept)  infl_d = infl_d + CW'(1);
    if (done_ok) infl_d = infl_d - CW'(1);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      res_wr_q <= '0;
      res_rd_q <= '0;
      occ_q    <= '0;
      infl_q   <= '0;
    end else begin
      if (accept)  tag_wr_q <= tag_wr_q + AW'(1);
      if (done_ok) tag_rd_q <= tag_rd_q + AW'(1);
      if (done_ok) res_wr_q <= res_wr_q + AW'(1);
      if (pop)     res_rd_q <= res_rd_q + AW'(1);
      occ_q  <= occ_d;
      infl_q <= infl_d;
    end
  end

  // Storage needs no reset: entries are only read once the counters mark them valid.
  always_ff @(posedge clk) begin
    if (accept)  tag_mem[tag_wr_q] <= bus.in_tag;
    if (done_ok) res_mem[res_wr_q] <= {bus.mul_result, tag_mem[tag_rd_q]};
  end

`ifdef MUL_DRV_TIMEOUT_EN
  logic [3:0] tmo_q;
  logic       err_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (bus.mul_done || infl_q == '0) begin
        tmo_q <= '0;
      end else if (tmo_q != 4'hF) begin
        tmo_q <= tmo_q + 4'h1;
      end
      // Error rises on the same edge the counter reaches 15.
      if ((bus.mul_done && infl_q == '0) ||
          (!bus.mul_done && infl_q != '0 && tmo_q == 4'hE)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: doc/mul_fp16_driver.md
MUL_FP16_DRIVER -- requirements
Module: mul_fp16_driver

Interface
REQ-001 Parameter: DEPTH, 4, result buffer entries and maximum outstanding multiplies; power of two, 2..16.
REQ-002 Parameter: TAG_W, 4, width of the caller tag carried alongside each operand pair.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge.
REQ-004 Port: nRST  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  upstream operand pair valid.
REQ-006 Port: in_ready  output  1  driver accepts operand pair this cycle.
REQ-007 Port: in_a, in_b  input  16 each  FP16 operands.
REQ-008 Port: in_tag  input  TAG_W  caller tag, returned with the result.
REQ-009 Port: mul_start  output  1  start strobe to mul_fp16.
REQ-010 Port: mul_a, mul_b  output  16 each  operands to mul_fp16.
REQ-011 Port: mul_result  input  16  FP16 product from mul_fp16.
REQ-012 Port: mul_done  input  1  one-cycle product-valid pulse from mul_fp16.
REQ-013 Port: out_valid  output  1  result available.
REQ-014 Port: out_ready  input  1  downstream accepts result.
REQ-015 Port: out_result  output  16  FP16 product at buffer head.
REQ-016 Port: out_tag  output  TAG_W  tag matching out_result.
REQ-017 Port: err  output  1  sticky protocol/timeout error; see Configuration.

Function
REQ-018 Accept = in_valid & in_ready; mul_start SHALL equal accept combinationally; mul_a/mul_b SHALL be in_a/in_b combinationally.
REQ-019 in_ready SHALL be 1 iff (buffer occupancy + in-flight count) < DEPTH, so every issued multiply has a guaranteed buffer slot; the multiplier never stalls.
REQ-020 Back-to-back accepts on consecutive cycles SHALL be allowed up to the credit limit.
REQ-021 On accept, in_tag SHALL be pushed into an in-order tag FIFO of DEPTH entries; in-flight count increments.
REQ-022 On mul_done with in-flight > 0: pop the tag FIFO, write {mul_result, tag} to the result buffer tail; in-flight decrements, occupancy increments.
REQ-023 mul_done with in-flight == 0 SHALL be ignored (no buffer write, no count change).
REQ-024 out_valid SHALL be 1 iff occupancy > 0; out_result/out_tag SHALL show the head entry and be stable while out_valid & ~out_ready.
REQ-025 Pop = out_valid & out_ready; occupancy decrements, head pointer advances.
REQ-026 Results SHALL leave in issue order.
REQ-027 Simultaneous accept, mul_done and pop in one cycle SHALL all take effect; counts net correctly.
REQ-028 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; counters SHALL be log2(DEPTH)+1 bits.
REQ-029 Pop while full and a mul_done in the same cycle SHALL NOT occur by construction (credit rule); no overflow is possible.

Reset
REQ-030 On nRST low: pointers, occupancy and in-flight count SHALL be 0; out_valid 0; err 0; timeout counter 0.
REQ-031 After reset, in_ready SHALL be 1 and mul_start follows in_valid.
REQ-032 Reset mid-operation SHALL discard all buffered and in-flight results; any late mul_done afterwards is dropped per REQ-023.

Configuration
REQ-033 Macro MUL_DRV_TIMEOUT_EN: when defined, a 4-bit counter SHALL count cycles with in-flight > 0 and no mul_done, clear on mul_done or when in-flight is 0, and set err when it reaches 15; mul_done with in-flight == 0 SHALL also set err; err stays 1 until reset.
REQ-034 Without MUL_DRV_TIMEOUT_EN: no counter is built and err SHALL be tied 0.

Verification
REQ-035 Single op: in_a=0x3C00 (1.0), in_b=0x4000 (2.0), tag=3, out_ready=1 -> one out_valid beat with out_result=0x4000, out_tag=3.
REQ-036 Streaming: 8 consecutive accepts, out_ready=1 -> in_ready stays 1, 8 results in issue order, tags 0..7.
REQ-037 Backpressure: out_ready=0, DEPTH=4, in_valid=1 -> exactly 4 accepts, then in_ready=0; after one pop, in_ready returns 1 for exactly one further accept.
REQ-038 Simultaneous: with occupancy 2, accept + mul_done + pop in same cycle -> occupancy stays 2, in-flight unchanged.
REQ-039 Reset mid-flight: 2 ops in flight, assert nRST low one cycle -> out_valid=0, in_ready=1, subsequent stray mul_done produces no output.
REQ-040 MUL_DRV_TIMEOUT_EN defined: issue one op, hold mul_done low -> err=1 on the 15th stalled cycle and remains 1; undefined -> err=0 throughout.
